// File: rtl/dk_mix_scheduler.sv
// Audio mixer: one shared MAC walks NUM_CH gained channels per sample strobe,
// then rounds, saturates and publishes one signed mixed sample.
module dk_mix_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 8
) (
    input  logic                         clk,
    input  logic                         I_RSTn,
    input  logic                         audio_clk_en,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_sample,
    input  logic [NUM_CH*GAIN_W-1:0]     ch_gain,
    input  logic [NUM_CH-1:0]            ch_enable,
    output logic [SAMPLE_W-1:0]          out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int PW    = SAMPLE_W + GAIN_W + 1;
    localparam int ACC_W = PW + $clog2(NUM_CH);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FRAC  = 7;

    localparam logic [IDX_W-1:0]        LAST  = IDX_W'(NUM_CH - 1);
    localparam logic signed [ACC_W:0]   ROUND = (ACC_W+1)'(64);
    localparam logic signed [ACC_W:0]   SMAX  =
        (ACC_W+1)'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0]   SMIN  = ~SMAX;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [NUM_CH*SAMPLE_W-1:0]    samp_q, samp_d;
    logic [NUM_CH*GAIN_W-1:0]      gain_q, gain_d;
    logic [NUM_CH-1:0]             en_q, en_d;
    logic [SAMPLE_W-1:0]           out_q, out_d;
    logic                          vld_q, vld_d;
    logic                          ovr_q, ovr_d;

    logic signed [SAMPLE_W-1:0]    s_cur;
    logic [GAIN_W-1:0]             g_cur;
    logic                          e_cur;
    logic signed [PW-1:0]          prod;
    logic signed [ACC_W-1:0]       acc_next;
    logic signed [ACC_W:0]         rnd;
    logic signed [ACC_W:0]         shf;
    logic [SAMPLE_W-1:0]           sat;

    // The single multiplier: operand chosen by idx from the snapshot regs.
    assign s_cur    = samp_q[idx_q*SAMPLE_W +: SAMPLE_W];
    assign g_cur    = gain_q[idx_q*GAIN_W +: GAIN_W];
    assign e_cur    = en_q[idx_q];
    assign prod     = PW'(s_cur) * $signed(PW'(g_cur));
    assign acc_next = e_cur ? acc_q + ACC_W'(prod) : acc_q;

    assign rnd = (ACC_W+1)'(acc_q) + ROUND;
    assign shf = rnd >>> FRAC;

    always_comb begin
        sat = shf[SAMPLE_W-1:0];
        if (shf > SMAX) begin
            sat = SMAX[SAMPLE_W-1:0];
        end else if (shf < SMIN) begin
            sat = SMIN[SAMPLE_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        samp_d  = samp_q;
        gain_d  = gain_q;
        en_d    = en_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    samp_d  = ch_sample;
                    gain_d  = ch_gain;
                    en_d    = ch_enable;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_next;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
                if (audio_clk_en) ovr_d = 1'b1;
            end
            OUT: begin
                out_d   = sat;
                vld_d   = 1'b1;
                state_d = IDLE;
                if (audio_clk_en) ovr_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            samp_q  <= '0;
            gain_q  <= '0;
            en_q    <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            samp_q  <= samp_d;
            gain_q  <= gain_d;
            en_q    <= en_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_dk_mix_scheduler.sv
// Directed plus randomized bench for dk_mix_scheduler against an
// arithmetic reference of the gain/sum/round/saturate rule.
module tb_dk_mix_scheduler;

    logic        clk = 1'b0;
    logic        I_RSTn;
    logic        audio_clk_en;
    logic [63:0] ch_sample;
    logic [31:0] ch_gain;
    logic [3:0]  ch_enable;
    logic [15:0] out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    int       s_m [4];
    int       g_m [4];
    bit [3:0] e_m;

    dk_mix_scheduler #(
        .NUM_CH  (4),
        .SAMPLE_W(16),
        .GAIN_W  (8)
    ) dut (
        .clk         (clk),
        .I_RSTn      (I_RSTn),
        .audio_clk_en(audio_clk_en),
        .ch_sample   (ch_sample),
        .ch_gain     (ch_gain),
        .ch_enable   (ch_enable),
        .out         (out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic longint model();
        longint acc = 0;
        for (int k = 0; k < 4; k++)
            if (e_m[k]) acc += longint'(s_m[k]) * longint'(g_m[k]);
        acc = (acc + 64) >>> 7;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < 4; k++) begin
            ch_sample[k*16 +: 16] = 16'(s_m[k]);
            ch_gain[k*8 +: 8]     = 8'(g_m[k]);
        end
        ch_enable = e_m;
    endtask

    task automatic scramble();
        ch_sample = {$urandom, $urandom};
        ch_gain   = $urandom;
        ch_enable = 4'($urandom);
    endtask

    task automatic set_ch(input int s0, s1, s2, s3,
                          input int g0, g1, g2, g3,
                          input bit [3:0] e);
        s_m[0] = s0; s_m[1] = s1; s_m[2] = s2; s_m[3] = s3;
        g_m[0] = g0; g_m[1] = g1; g_m[2] = g2; g_m[3] = g3;
        e_m = e;
    endtask

    task automatic randomize_ch();
        for (int k = 0; k < 4; k++) begin
            s_m[k] = int'($urandom_range(65535)) - 32768;
            g_m[k] = int'($urandom_range(255));
        end
        e_m = 4'($urandom);
    endtask

    // One clean pass; inputs are scrambled right after the strobe edge.
    task automatic run_pass(input string tag);
        longint exp;
        int     n;
        int     b;
        exp = model();
        @(negedge clk);
        apply();
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        audio_clk_en = 1'b0;
        scramble();
        n = 0;
        b = 0;
        while (n < 20 && !out_valid) begin
            if (busy) b++;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, 5);
        chk({tag, "_busycyc"}, b, 5);
        chk({tag, "_busy0"}, busy, 0);
        chk({tag, "_out"}, $signed(out), exp);
        @(posedge clk);
        #1;
        chk({tag, "_vpulse"}, out_valid, 0);
        chk({tag, "_hold"}, $signed(out), exp);
    endtask

    initial begin
        longint exp;
        int     n;
        int     p;

        I_RSTn       = 1'b0;
        audio_clk_en = 1'b0;
        ch_sample    = '0;
        ch_gain      = '0;
        ch_enable    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        I_RSTn = 1'b1;

        set_ch(1000, 0, 0, 0, 128, 0, 0, 0, 4'b0001);
        run_pass("unity");
        chk("unity_lit", $signed(out), 1000);

        set_ch(1000, -500, 300, 7, 128, 64, 255, 200, 4'b0111);
        run_pass("mix");
        chk("mix_lit", $signed(out), 1348);

        set_ch(32767, 32767, 32767, 32767, 255, 255, 255, 255, 4'b1111);
        run_pass("satp");
        chk("satp_lit", $signed(out), 32767);

        set_ch(-32768, -32768, -32768, -32768, 255, 255, 255, 255, 4'b1111);
        run_pass("satn");
        chk("satn_lit", $signed(out), -32768);

        randomize_ch();
        e_m = 4'b0000;
        run_pass("alloff");
        chk("alloff_lit", $signed(out), 0);

        for (int i = 0; i < 12; i++) begin
            randomize_ch();
            run_pass($sformatf("rnd%0d", i));
        end
        chk("ovr_pre", overrun, 0);

        // Second strobe two cycles into the pass must be ignored.
        set_ch(1000, -500, 300, 7, 128, 64, 255, 200, 4'b0111);
        exp = model();
        @(negedge clk);
        apply();
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        audio_clk_en = 1'b0;
        scramble();
        @(posedge clk);
        #1;
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        audio_clk_en = 1'b0;
        n = 2;
        while (n < 20 && !out_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ovr_lat", n, 5);
        chk("ovr_out", $signed(out), exp);
        chk("ovr_flag", overrun, 1);
        p = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) p++;
        end
        chk("ovr_nosecond", p, 0);
        randomize_ch();
        run_pass("ovr_clean");
        chk("ovr_sticky", overrun, 1);

        // Reset while idx=2 aborts the pass.
        set_ch(1000, 0, 0, 0, 128, 0, 0, 0, 4'b0001);
        @(negedge clk);
        apply();
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        audio_clk_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        I_RSTn = 1'b0;
        @(posedge clk);
        #1;
        I_RSTn = 1'b1;
        p = 0;
        repeat (8) begin
            if (out_valid) p++;
            @(posedge clk);
            #1;
        end
        chk("abort_novalid", p, 0);
        chk("abort_out", out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ovr", overrun, 0);
        run_pass("after_abort");
        chk("after_abort_lit", $signed(out), 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
